stage2_window_gen: RTL and testbench

Streaming 5x5 sliding-window generator that sits directly upstream of `stage2_cnn_kernel`. It accepts the stage-1 output feature map one pixel per valid cycle in raster order. Four row-delay line buffers and a 5x5 register window assemble every fully-populated 5x5 neighbourhood, which is emitted as the flattened `i_in_fmap` bus the stage-2 kernel consumes. There is no back-pressure: the downstream kernel accepts one window per cycle unconditionally.

---
 rtl/stage2_window_gen_pkg.sv | 10 +
 rtl/stage2_line_buffer.sv | 42 ++++
 rtl/stage2_window_gen.sv | 112 +++++++++++
 tb/tb_stage2_window_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stage2_window_gen_pkg.sv
// rtl/stage2_window_gen_pkg.sv - shared stage-2 geometry and pixel width
package stage2_window_gen_pkg;

  localparam int ST2_KX       = 5;
  localparam int ST2_KY       = 5;
  localparam int ST2_Conv_IBW = 20;
  localparam int ST2_IW       = 12;
  localparam int ST2_IH       = 12;

endpackage

// File: rtl/stage2_line_buffer.sv
// rtl/stage2_line_buffer.sv - one-row pixel delay, RAM-inferable, no reset on storage
module stage2_line_buffer #(
  parameter int DEPTH = 12,
  parameter int BW    = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_en,
  input  logic [BW-1:0] i_data,
  output logic [BW-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;

  // Read-before-write at the same slot gives exactly DEPTH accepted pixels of delay.
  assign o_data = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (i_en) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      mem_q[ptr_q] <= i_data;
    end
  end

endmodule

// File: rtl/stage2_window_gen.sv
// rtl/stage2_window_gen.sv - streaming KXxKY sliding-window generator feeding stage2_cnn_kernel
module stage2_window_gen
  import stage2_window_gen_pkg::*;
#(
  parameter int IW  = ST2_IW,
  parameter int IH  = ST2_IH,
  parameter int KX  = ST2_KX,
  parameter int KY  = ST2_KY,
  parameter int IBW = ST2_Conv_IBW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_in_valid,
  input  logic [IBW-1:0]        i_in_fmap,
  output logic                  o_ot_valid,
  output logic [KX*KY*IBW-1:0]  o_ot_fmap,
  output logic                  o_frame_done
);

  localparam int CW = (IW > 1) ? $clog2(IW) : 1;
  localparam int RW = (IH > 1) ? $clog2(IH) : 1;
  localparam int WW = KX * KY * IBW;

  logic          accept;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, row_last, emit, frame_end;
  logic [WW-1:0] win_q, win_d, fmap_q;
  logic          valid_q, done_q;

  // lb_data[k] is the pixel at the current column from k rows earlier.
  logic [IBW-1:0] lb_data [KY];

  assign accept    = i_in_valid & ~i_clear;
  assign col_last  = (col_q == CW'(IW - 1));
  assign row_last  = (row_q == RW'(IH - 1));
  assign emit      = accept & (row_q >= RW'(KY - 1)) & (col_q >= CW'(KX - 1));
  assign frame_end = accept & row_last & col_last;

  assign lb_data[0] = i_in_fmap;

  for (genvar k = 0; k < KY - 1; k++) begin : g_lb
    stage2_line_buffer #(
      .DEPTH (IW),
      .BW    (IBW)
    ) u_line_buffer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (accept),
      .i_data  (lb_data[k]),
      .o_data  (lb_data[k+1])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_clear) begin
      col_d = '0;
      row_d = '0;
    end else if (i_in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Rows shift left; the rightmost column takes the newest pixel (bottom) and line-buffer taps above it.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX; x++) begin
          if (x < KX - 1) begin
            win_d[(y*KX+x)*IBW +: IBW] = win_q[(y*KX+x+1)*IBW +: IBW];
          end else begin
            win_d[(y*KX+x)*IBW +: IBW] = lb_data[KY-1-y];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      fmap_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= emit;
      done_q  <= frame_end;
      if (emit) begin
        fmap_q <= win_d;
      end
    end
  end

  assign o_ot_valid   = valid_q;
  assign o_ot_fmap    = fmap_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_stage2_window_gen.sv
// tb/tb_stage2_window_gen.sv - scoreboard bench for stage2_window_gen
module tb_stage2_window_gen;

  localparam int IW  = 12;
  localparam int IH  = 12;
  localparam int KX  = 5;
  localparam int KY  = 5;
  localparam int IBW = 20;
  localparam int WW  = KX * KY * IBW;

  logic           clk;
  logic           reset_n;
  logic           i_clear;
  logic           i_in_valid;
  logic [IBW-1:0] i_in_fmap;
  logic           o_ot_valid;
  logic [WW-1:0]  o_ot_fmap;
  logic           o_frame_done;

  stage2_window_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (i_clear),
    .i_in_valid   (i_in_valid),
    .i_in_fmap    (i_in_fmap),
    .o_ot_valid   (o_ot_valid),
    .o_ot_fmap    (o_ot_fmap),
    .o_frame_done (o_frame_done)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t           sb [$];
  logic [IBW-1:0] img [IH][IW];
  int             mr, mc;
  int             cyc;
  int             win_cnt;
  int             n_cmp;
  int             n_bad;
  int             w0;
  exp_t           me;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] build_win(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int y = 0; y < KY; y++)
      for (int x = 0; x < KX; x++)
        w[(y*KX+x)*IBW +: IBW] = img[r-KY+1+y][c-KX+1+x];
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_in_valid = 1'b0;
      i_clear    = 1'b0;
      i_in_fmap  = IBW'($urandom);
    end
  endtask

  task automatic send(input logic [IBW-1:0] v, input bit clr);
    exp_t e;
    @(negedge clk);
    i_in_valid = 1'b1;
    i_clear    = clr;
    i_in_fmap  = v;
    if (clr) begin
      mr = 0;
      mc = 0;
    end else begin
      img[mr][mc] = v;
      if (mr >= KY - 1 && mc >= KX - 1) begin
        e.win  = build_win(mr, mc);
        e.done = (mr == IH - 1) && (mc == IW - 1);
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      if (mc == IW - 1) begin
        mc = 0;
        mr = (mr == IH - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
  endtask

  task automatic ramp(input logic [IBW-1:0] base, input int gapmax, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gapmax > 0) idle($urandom_range(gapmax, 0));
      send(base + IBW'((i / IW) * 16 + (i % IW)), 1'b0);
    end
  endtask

  // Monitor: every valid window must match the head of the scoreboard, one cycle after its pixel.
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("done_needs_valid", WW'(o_frame_done & ~o_ot_valid), '0);
    if (o_ot_valid) begin
      chk("sb_underflow", WW'(sb.size() == 0), '0);
      if (sb.size() != 0) begin
        me = sb.pop_front();
        chk("win", o_ot_fmap, me.win);
        chk("frame_done", WW'(o_frame_done), WW'(me.done));
        chk("latency", WW'(cyc), WW'(me.cyc));
        win_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IBW-1:0] v;
    n_cmp = 0; n_bad = 0; cyc = 0; win_cnt = 0; mr = 0; mc = 0;
    reset_n = 1'b0; i_clear = 1'b0; i_in_valid = 1'b0; i_in_fmap = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", WW'(o_ot_valid), '0);
    chk("rst_fmap", o_ot_fmap, '0);
    chk("rst_done", WW'(o_frame_done), '0);
    reset_n = 1'b1;

    w0 = win_cnt;
    ramp('0, 0, IW * IH);
    idle(4);
    chk("ramp_cnt", WW'(win_cnt - w0), WW'(64));
    chk("ramp_last00", WW'(o_ot_fmap[0 +: IBW]), WW'(20'h77));
    chk("ramp_last44", WW'(o_ot_fmap[24*IBW +: IBW]), WW'(20'hBB));
    chk("hold_novalid", WW'(o_ot_valid), '0);

    w0 = win_cnt;
    ramp('0, 3, IW * IH);
    idle(4);
    chk("gap_cnt", WW'(win_cnt - w0), WW'(64));

    w0 = win_cnt;
    ramp('0, 0, IW * IH);
    ramp(20'h100, 0, IW * IH);
    idle(4);
    chk("b2b_cnt", WW'(win_cnt - w0), WW'(128));
    chk("b2b_last00", WW'(o_ot_fmap[0 +: IBW]), WW'(20'h177));

    w0 = win_cnt;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        v = IBW'($urandom);
        if (r == 0 && c == 0)  v = 20'hFFFFF;
        if (r == 0 && c == 4)  v = 20'h80000;
        if (r == 4 && c == 0)  v = 20'h7FFFF;
        if (r == 4 && c == 4)  v = 20'hFFFFF;
        if (r == 11 && c == 11) v = 20'h80000;
        send(v, 1'b0);
      end
    end
    idle(4);
    chk("neg_cnt", WW'(win_cnt - w0), WW'(64));
    chk("neg_last44", WW'(o_ot_fmap[24*IBW +: IBW]), WW'(20'h80000));

    w0 = win_cnt;
    ramp('0, 0, 6 * IW + 3);
    send(20'h63, 1'b1);
    @(posedge clk);
    #2;
    chk("clr_novalid", WW'(o_ot_valid), '0);
    ramp('0, 0, IW * IH);
    idle(4);
    chk("clr_cnt", WW'(win_cnt - w0), WW'(16 + 64));

    w0 = win_cnt;
    ramp('0, 0, 7 * IW + 7);
    @(negedge clk);
    i_in_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("mrst_valid", WW'(o_ot_valid), '0);
    chk("mrst_fmap", o_ot_fmap, '0);
    chk("mrst_done", WW'(o_frame_done), '0);
    repeat (2) @(negedge clk);
    chk("mrst_fmap_hold", o_ot_fmap, '0);
    reset_n = 1'b1;
    mr = 0;
    mc = 0;
    ramp('0, 0, IW * IH);
    idle(4);
    chk("mrst_cnt", WW'(win_cnt - w0), WW'(27 + 64));

    chk("sb_drained", WW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
